// File: rtl/pll_reconfig_sequencer.sv
// Avalon-MM master that loads n/m/c0 divide settings into the reconfigurable
// PLL parameter cache, triggers reconfiguration and polls status until done.
//
// state      | meaning
// -----------+------------------------------------------------------------
// S_IDLE     | ready for a command; captures n/m/c0 on accept
// S_CHECK    | rejects any zero divide value, otherwise starts the sequence
// S_WRITE    | writes the 12 counter fields, idx selects param/type
// S_GO       | writes the reconfig trigger at 0x80
// S_SETTLE   | bus idle for SETTLE_CYCLES before the first status read
// S_POLL     | reads status at 0x80, 0x0D means reconfiguration finished
// S_POLL_GAP | one idle cycle between consecutive status reads
// S_DONE     | one-cycle done pulse
module pll_reconfig_sequencer #(
    parameter int POLL_LIMIT    = 65535,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic        csi_clk_clock,
    input  logic        csi_clk_reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [8:0]  cmd_n,
    input  logic [8:0]  cmd_m,
    input  logic [8:0]  cmd_c0,
    output logic        busy,
    output logic        done,
    output logic [1:0]  error,
    output logic [7:0]  avm_address,
    output logic [31:0] avm_writedata,
    output logic        avm_write,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest
);

    localparam int PW = (POLL_LIMIT > 1) ? $clog2(POLL_LIMIT + 1) : 1;
    localparam int SW = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [PW-1:0] POLL_LAST   = PW'(POLL_LIMIT - 1);
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
    localparam logic [7:0]    ADDR_CTRL   = 8'h80;
    localparam logic [7:0]    STATUS_DONE = 8'h0D;
    localparam logic [3:0]    IDX_LAST    = 4'd11;
    localparam logic [1:0]    ERR_OK      = 2'd0;
    localparam logic [1:0]    ERR_ZERO    = 2'd1;
    localparam logic [1:0]    ERR_TIMEOUT = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_WRITE,
        S_GO,
        S_SETTLE,
        S_POLL,
        S_POLL_GAP,
        S_DONE
    } state_t;

    state_t         state, state_nxt;
    logic [3:0]     idx, idx_nxt;
    logic [SW-1:0]  settle_cnt, settle_nxt;
    logic [PW-1:0]  poll_cnt, poll_nxt;
    logic [1:0]     error_q, error_nxt;
    logic [8:0]     n_q, m_q, c0_q;
    logic           cap_en;

    logic [8:0]     fld_val;
    logic [2:0]     prm_code;
    logic [3:0]     typ_code;
    logic [9:0]     fld_high;
    logic [9:0]     fld_low;
    logic [31:0]    fld_data;
    logic           any_zero;

    // Only the low status byte carries meaning.
    logic           unused_rdata;
    assign unused_rdata = ^avm_readdata[31:8];

    assign error    = error_q;
    assign any_zero = (n_q == 9'd0) || (m_q == 9'd0) || (c0_q == 9'd0);

    // Field value, address code and write data for the current write index.
    always_comb begin
        fld_val  = n_q;
        prm_code = 3'd0;
        typ_code = 4'd0;
        fld_data = 32'd0;
        case (idx[3:2])
            2'd0:    begin fld_val = n_q;  prm_code = 3'd0; end
            2'd1:    begin fld_val = m_q;  prm_code = 3'd1; end
            default: begin fld_val = c0_q; prm_code = 3'd4; end
        endcase
        fld_high = ({1'b0, fld_val} + 10'd1) >> 1;
        fld_low  = {1'b0, fld_val} - fld_high;
        case (idx[1:0])
            2'd0:    begin typ_code = 4'd0; fld_data = {22'd0, fld_high}; end
            2'd1:    begin typ_code = 4'd1; fld_data = {22'd0, fld_low}; end
            2'd2:    begin typ_code = 4'd4; fld_data = {31'd0, (fld_val == 9'd1)}; end
            default: begin typ_code = 4'd5; fld_data = {31'd0, fld_val[0]}; end
        endcase
    end

    // Next-state logic and Moore bus outputs; strobes derive from state so
    // they fall as soon as reset forces the state register to idle.
    always_comb begin
        state_nxt     = state;
        idx_nxt       = idx;
        settle_nxt    = settle_cnt;
        poll_nxt      = poll_cnt;
        error_nxt     = error_q;
        cap_en        = 1'b0;
        cmd_ready     = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        avm_write     = 1'b0;
        avm_read      = 1'b0;
        avm_address   = 8'h00;
        avm_writedata = 32'd0;
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    cap_en    = 1'b1;
                    error_nxt = ERR_OK;
                    state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                if (any_zero) begin
                    error_nxt = ERR_ZERO;
                    state_nxt = S_IDLE;
                end else begin
                    error_nxt = ERR_OK;
                    idx_nxt   = 4'd0;
                    state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                busy          = 1'b1;
                avm_write     = 1'b1;
                avm_address   = {1'b0, prm_code, typ_code};
                avm_writedata = fld_data;
                if (!avm_waitrequest) begin
                    if (idx == IDX_LAST) begin
                        state_nxt = S_GO;
                    end else begin
                        idx_nxt = idx + 4'd1;
                    end
                end
            end
            S_GO: begin
                busy        = 1'b1;
                avm_write   = 1'b1;
                avm_address = ADDR_CTRL;
                if (!avm_waitrequest) begin
                    settle_nxt = SETTLE_LOAD;
                    state_nxt  = S_SETTLE;
                end
            end
            S_SETTLE: begin
                busy = 1'b1;
                if (settle_cnt == '0) begin
                    poll_nxt  = '0;
                    state_nxt = S_POLL;
                end else begin
                    settle_nxt = settle_cnt - 1'b1;
                end
            end
            S_POLL: begin
                busy        = 1'b1;
                avm_read    = 1'b1;
                avm_address = ADDR_CTRL;
                if (!avm_waitrequest) begin
                    if (avm_readdata[7:0] == STATUS_DONE) begin
                        state_nxt = S_DONE;
                    end else if (poll_cnt == POLL_LAST) begin
                        error_nxt = ERR_TIMEOUT;
                        state_nxt = S_IDLE;
                    end else begin
                        poll_nxt  = poll_cnt + 1'b1;
                        state_nxt = S_POLL_GAP;
                    end
                end
            end
            S_POLL_GAP: begin
                busy      = 1'b1;
                state_nxt = S_POLL;
            end
            S_DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State, counters, sticky error and captured command registers.
    always_ff @(posedge csi_clk_clock or negedge csi_clk_reset_n) begin
        if (!csi_clk_reset_n) begin
            state      <= S_IDLE;
            idx        <= 4'd0;
            settle_cnt <= '0;
            poll_cnt   <= '0;
            error_q    <= ERR_OK;
            n_q        <= 9'd0;
            m_q        <= 9'd0;
            c0_q       <= 9'd0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            settle_cnt <= settle_nxt;
            poll_cnt   <= poll_nxt;
            error_q    <= error_nxt;
            if (cap_en) begin
                n_q  <= cmd_n;
                m_q  <= cmd_m;
                c0_q <= cmd_c0;
            end
        end
    end

endmodule

// File: tb/tb_pll_reconfig_sequencer.sv
// Directed bench for pll_reconfig_sequencer: expected writes are queued when
// a command is issued and popped as the slave model sees each write complete.
module tb_pll_reconfig_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [8:0]  cmd_n, cmd_m, cmd_c0;
    logic        busy, done;
    logic [1:0]  error;
    logic [7:0]  avm_address;
    logic [31:0] avm_writedata;
    logic        avm_write, avm_read;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [39:0] exp_q[$];
    int          write_cnt = 0;
    int          read_cnt  = 0;
    int          done_cnt  = 0;
    int          cyc       = 0;
    int          go_cyc    = 0;
    int          settle_gap = 0;
    logic        first_rd_pending = 1'b0;
    logic        both_seen = 1'b0;
    logic        stall_mode = 1'b0;
    logic        hold_en = 1'b0;
    int          busy_reads = 0;
    int          reads_this_cmd = 0;

    always #5 clk = ~clk;

    pll_reconfig_sequencer #(
        .POLL_LIMIT    (16),
        .SETTLE_CYCLES (4)
    ) dut (
        .csi_clk_clock   (clk),
        .csi_clk_reset_n (rst_n),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_n           (cmd_n),
        .cmd_m           (cmd_m),
        .cmd_c0          (cmd_c0),
        .busy            (busy),
        .done            (done),
        .error           (error),
        .avm_address     (avm_address),
        .avm_writedata   (avm_writedata),
        .avm_write       (avm_write),
        .avm_read        (avm_read),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference field model: high/low/bypass/odd per divide value.
    function automatic void push_model(input logic [8:0] n, input logic [8:0] m, input logic [8:0] c0);
        logic [8:0] v;
        logic [2:0] pc;
        logic [9:0] hi, lo;
        for (int p = 0; p < 3; p++) begin
            v  = (p == 0) ? n : (p == 1) ? m : c0;
            pc = (p == 0) ? 3'd0 : (p == 1) ? 3'd1 : 3'd4;
            hi = ({1'b0, v} + 10'd1) >> 1;
            lo = {1'b0, v} - hi;
            exp_q.push_back({1'b0, pc, 4'd0, 22'd0, hi});
            exp_q.push_back({1'b0, pc, 4'd1, 22'd0, lo});
            exp_q.push_back({1'b0, pc, 4'd4, 31'd0, (v == 9'd1)});
            exp_q.push_back({1'b0, pc, 4'd5, 31'd0, v[0]});
        end
        exp_q.push_back({8'h80, 32'd0});
    endfunction

    // n=5, m=10, c0=4
    function automatic void push_tbl1();
        exp_q.push_back({8'h00, 32'd3}); exp_q.push_back({8'h01, 32'd2});
        exp_q.push_back({8'h04, 32'd0}); exp_q.push_back({8'h05, 32'd1});
        exp_q.push_back({8'h10, 32'd5}); exp_q.push_back({8'h11, 32'd5});
        exp_q.push_back({8'h14, 32'd0}); exp_q.push_back({8'h15, 32'd0});
        exp_q.push_back({8'h40, 32'd2}); exp_q.push_back({8'h41, 32'd2});
        exp_q.push_back({8'h44, 32'd0}); exp_q.push_back({8'h45, 32'd0});
        exp_q.push_back({8'h80, 32'd0});
    endfunction

    // n=1, m=511, c0=2
    function automatic void push_tbl2();
        exp_q.push_back({8'h00, 32'd1});   exp_q.push_back({8'h01, 32'd0});
        exp_q.push_back({8'h04, 32'd1});   exp_q.push_back({8'h05, 32'd1});
        exp_q.push_back({8'h10, 32'd256}); exp_q.push_back({8'h11, 32'd255});
        exp_q.push_back({8'h14, 32'd0});   exp_q.push_back({8'h15, 32'd1});
        exp_q.push_back({8'h40, 32'd1});   exp_q.push_back({8'h41, 32'd1});
        exp_q.push_back({8'h44, 32'd0});   exp_q.push_back({8'h45, 32'd0});
        exp_q.push_back({8'h80, 32'd0});
    endfunction

    task automatic run_cmd(input logic [8:0] n, input logic [8:0] m, input logic [8:0] c0);
        int k;
        k = 0;
        while (!cmd_ready && k < 100) begin @(posedge clk); #1; k++; end
        cmd_n = n; cmd_m = m; cmd_c0 = c0;
        reads_this_cmd = 0;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int k;
        k = 0;
        while (!cmd_ready && k < budget) begin @(posedge clk); #1; k++; end
        check({tag, "_idle"}, cmd_ready, 1'b1);
        @(posedge clk); #1;
    endtask

    // Avalon slave model and write/read monitor.
    initial begin : slave_monitor
        logic        req;
        logic        active;
        int          stall_left;
        logic [7:0]  a0;
        logic [31:0] d0;
        logic [31:0] r;
        logic [39:0] e;
        active = 1'b0;
        stall_left = 0;
        avm_waitrequest = 1'b0;
        avm_readdata = 32'd0;
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (done) done_cnt++;
            if (avm_write && avm_read) both_seen = 1'b1;
            req = avm_write || avm_read;
            if (!req) begin
                active = 1'b0;
                avm_waitrequest = 1'b0;
            end else begin
                if (!active) begin
                    active = 1'b1;
                    a0 = avm_address;
                    d0 = avm_writedata;
                    stall_left = (stall_mode && avm_write) ? $urandom_range(0, 3) : 0;
                    if (avm_read) begin
                        r = $urandom();
                        avm_readdata = {r[31:8], (reads_this_cmd < busy_reads) ? 8'h0B : 8'h0D};
                        if (first_rd_pending) begin
                            settle_gap = cyc - go_cyc;
                            first_rd_pending = 1'b0;
                        end
                    end
                end else begin
                    check("stall_addr_stable", avm_address, a0);
                    check("stall_data_stable", avm_writedata, d0);
                end
                if (hold_en && avm_write && avm_address == 8'h14) begin
                    avm_waitrequest = 1'b1;
                end else if (stall_left > 0) begin
                    avm_waitrequest = 1'b1;
                    stall_left--;
                end else begin
                    avm_waitrequest = 1'b0;
                end
                if (!avm_waitrequest) begin
                    active = 1'b0;
                    if (avm_write) begin
                        write_cnt++;
                        if (avm_address == 8'h80) begin
                            go_cyc = cyc;
                            first_rd_pending = 1'b1;
                        end
                        check("write_expected_avail", (exp_q.size() != 0), 1'b1);
                        if (exp_q.size() != 0) begin
                            e = exp_q.pop_front();
                            check("write_addr_data", {avm_address, avm_writedata}, e);
                        end
                    end else begin
                        read_cnt++;
                        reads_this_cmd++;
                        check("read_addr", avm_address, 8'h80);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int w0, r0, d0;
        logic [8:0] rn, rm, rc;
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_n = 9'd0; cmd_m = 9'd0; cmd_c0 = 9'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_error", error, 2'd0);
        check("rst_write", avm_write, 1'b0);
        check("rst_read", avm_read, 1'b0);
        check("rst_address", avm_address, 8'h00);
        check("rst_writedata", avm_writedata, 32'd0);

        // Basic sequence, no stalls, status done on first read.
        push_tbl1();
        w0 = write_cnt; r0 = read_cnt; d0 = done_cnt;
        run_cmd(9'd5, 9'd10, 9'd4);
        check("s1_check_not_ready", cmd_ready, 1'b0);
        check("s1_check_busy", busy, 1'b0);
        @(posedge clk); #1;
        check("s1_write_busy", busy, 1'b1);
        wait_idle(300, "s1");
        check("s1_writes", write_cnt - w0, 13);
        check("s1_queue_empty", exp_q.size(), 0);
        check("s1_reads", read_cnt - r0, 1);
        check("s1_settle_gap", settle_gap, 5);
        check("s1_done_pulses", done_cnt - d0, 1);
        check("s1_error", error, 2'd0);
        check("s1_busy_after", busy, 1'b0);

        // Boundary values: bypass on n=1, widest m.
        push_tbl2();
        w0 = write_cnt; d0 = done_cnt;
        run_cmd(9'd1, 9'd511, 9'd2);
        wait_idle(300, "s2");
        check("s2_writes", write_cnt - w0, 13);
        check("s2_queue_empty", exp_q.size(), 0);
        check("s2_done_pulses", done_cnt - d0, 1);

        // Random waitrequest stalls on writes.
        stall_mode = 1'b1;
        push_tbl1();
        w0 = write_cnt; d0 = done_cnt;
        run_cmd(9'd5, 9'd10, 9'd4);
        wait_idle(400, "s3");
        check("s3_writes", write_cnt - w0, 13);
        check("s3_queue_empty", exp_q.size(), 0);
        check("s3_done_pulses", done_cnt - d0, 1);

        // Seven busy status reads then done, random divide values.
        busy_reads = 7;
        rn = 9'($urandom_range(1, 511));
        rm = 9'($urandom_range(1, 511));
        rc = 9'($urandom_range(1, 511));
        push_model(rn, rm, rc);
        w0 = write_cnt; r0 = read_cnt; d0 = done_cnt;
        run_cmd(rn, rm, rc);
        wait_idle(400, "s4");
        check("s4_queue_empty", exp_q.size(), 0);
        check("s4_reads", read_cnt - r0, 8);
        check("s4_done_pulses", done_cnt - d0, 1);
        check("s4_error", error, 2'd0);
        stall_mode = 1'b0;

        // Status never completes: timeout after POLL_LIMIT reads.
        busy_reads = 1000;
        push_model(9'd9, 9'd9, 9'd9);
        r0 = read_cnt; d0 = done_cnt;
        run_cmd(9'd9, 9'd9, 9'd9);
        wait_idle(400, "s5");
        check("s5_queue_empty", exp_q.size(), 0);
        check("s5_reads", read_cnt - r0, 16);
        check("s5_error", error, 2'd2);
        check("s5_busy", busy, 1'b0);
        check("s5_no_done", done_cnt - d0, 0);
        busy_reads = 0;

        // Zero m: rejected with no bus activity; old error cleared on accept.
        w0 = write_cnt; r0 = read_cnt; d0 = done_cnt;
        run_cmd(9'd5, 9'd0, 9'd4);
        check("s6_error_cleared", error, 2'd0);
        check("s6_in_check", cmd_ready, 1'b0);
        @(posedge clk); #1;
        check("s6_error_zero", error, 2'd1);
        check("s6_ready", cmd_ready, 1'b1);
        check("s6_busy", busy, 1'b0);
        repeat (3) @(posedge clk); #1;
        check("s6_no_writes", write_cnt - w0, 0);
        check("s6_no_reads", read_cnt - r0, 0);
        check("s6_no_done", done_cnt - d0, 0);
        check("s6_error_sticky", error, 2'd1);

        // Reset while write idx=6 is stalled.
        hold_en = 1'b1;
        push_tbl1();
        run_cmd(9'd5, 9'd10, 9'd4);
        begin
            int k;
            k = 0;
            while (!(avm_write && avm_address == 8'h14) && k < 200) begin @(posedge clk); #1; k++; end
            check("s7_reached_idx6", (avm_write && avm_address == 8'h14), 1'b1);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("s7_write_drop", avm_write, 1'b0);
        check("s7_read_drop", avm_read, 1'b0);
        check("s7_addr_drop", avm_address, 8'h00);
        check("s7_busy_drop", busy, 1'b0);
        hold_en = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("s7_ready_after", cmd_ready, 1'b1);
        check("s7_error_after", error, 2'd0);
        check("s7_writes_done_before_reset", exp_q.size(), 7);
        exp_q.delete();

        // A fresh command runs the whole sequence again.
        push_tbl1();
        d0 = done_cnt;
        run_cmd(9'd5, 9'd10, 9'd4);
        wait_idle(300, "s8");
        check("s8_queue_empty", exp_q.size(), 0);
        check("s8_done_pulses", done_cnt - d0, 1);

        check("never_read_and_write", both_seen, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
